// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: packs field-level instruction descriptors into 32-bit
// ISA words and writes them sequentially into instruction memory from a
// programmable base address. Used on the boot path before the CPU runs.
//
// Optional build macro: INSN_LOADER_CHECKSUM_EN adds a 32-bit running-XOR
// checksum output over every written word.
module insn_encoder_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
`ifdef INSN_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic              err_opcode,
  output logic              err_overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  // Opcode map shared with the processor's decoder.
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  // Pointer is one bit wider than the address so it can sit one past the
  // last legal word without wrapping back to 0.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  // Returns {unknown_opcode, packed_word}; unknown opcodes pack to a nop.
  function automatic logic [32:0] pack_word(
    input logic [4:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  shamt,
    input logic [4:0]  aluop,
    input logic [16:0] imm,
    input logic [26:0] target
  );
    logic [32:0] res;
    case (op)
      OP_R:                                   res = {1'b0, op, rd, rs, rt, shamt, aluop, 2'b00};
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT:  res = {1'b0, op, rd, rs, imm};
      OP_J, OP_JAL, OP_BEX, OP_SETX:          res = {1'b0, op, target};
      OP_JR:                                  res = {1'b0, op, rd, 22'd0};
      default:                                res = {1'b1, 32'd0};
    endcase
    return res;
  endfunction

  state_t             state;
  logic [ADDR_W:0]    ptr;
  logic               vld_p0;
  logic               bad_p0;
  logic [31:0]        word_p0;
  logic               room_p0;

  // Stage p0: accept handshake and combinational packing of the descriptor.
  always_comb begin
    vld_p0             = in_valid & in_ready;
    room_p0            = (ptr <= LAST_ADDR);
    {bad_p0, word_p0}  = pack_word(in_opcode, in_rd, in_rs, in_rt,
                                   in_shamt, in_aluop, in_imm, in_target);
  end

  // Stage p1: session FSM; an accepted word is registered straight onto the
  // memory port, giving one write per accept with a single cycle of latency.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      ptr          <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      count        <= '0;
      err_opcode   <= 1'b0;
      err_overflow <= 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr          <= {1'b0, base_addr};
            count        <= '0;
            err_opcode   <= 1'b0;
            err_overflow <= 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (vld_p0) begin
            if (room_p0) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr[ADDR_W-1:0];
              imem_data  <= word_p0;
              ptr        <= ptr + 1'b1;
              count      <= count + 1'b1;
              if (bad_p0) err_opcode <= 1'b1;
`ifdef INSN_LOADER_CHECKSUM_EN
              checksum   <= checksum ^ word_p0;
`endif
            end else begin
              err_overflow <= 1'b1;
            end
            // Memory exhausted ends the session just like the last descriptor.
            if (in_last || !room_p0) begin
              in_ready <= 1'b0;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The final write is on the port during this cycle.
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Directed testbench for insn_encoder_loader.
module tb_insn_encoder_loader;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
  logic [4:0]  in_shamt = '0, in_aluop = '0;
  logic [16:0] in_imm = '0;
  logic [26:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        busy, done;
  logic [12:0] count;
  logic        err_opcode, err_overflow;
`ifdef INSN_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  insn_encoder_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
    .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .busy(busy), .done(done), .count(count),
`ifdef INSN_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .err_opcode(err_opcode), .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

  // Stimulus helpers (drive only, no checking).
  task automatic set_desc(input logic [4:0] op, input logic [4:0] rd,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] sh, input logic [4:0] alu,
                          input logic [16:0] imm, input logic [26:0] tgt,
                          input logic last);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt; in_last = last;
  endtask

  task automatic do_start(input logic [11:0] base);
    @(negedge clock); start = 1'b1; base_addr = base;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", imem_we); end
    n_cmp++; if ({busy, done, err_opcode, err_overflow} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err_opcode, err_overflow}); end
    n_cmp++; if ({imem_addr, imem_data, count} !== 57'd0) begin n_fail++; $display("FAIL reset_regs: got %h/%h/%h want 0/0/0", imem_addr, imem_data, count); end
    @(negedge clock); resetn = 1'b1;
  endtask

  task automatic test_single_addi;
    do_start(12'h010);
    n_cmp++; if ({in_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL addi_ready_busy: got %b want 11", {in_ready, busy}); end
    set_desc(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL addi_we: got %b want 1", imem_we); end
    n_cmp++; if (imem_addr !== 12'h010) begin n_fail++; $display("FAIL addi_addr: got %h want 010", imem_addr); end
    n_cmp++; if (imem_data !== 32'h28400005) begin n_fail++; $display("FAIL addi_data: got %h want 28400005", imem_data); end
    n_cmp++; if ({in_ready, busy, done} !== 3'b010) begin n_fail++; $display("FAIL addi_flush: got %b want 010", {in_ready, busy, done}); end
    @(negedge clock);
    n_cmp++; if ({done, busy, imem_we} !== 3'b100) begin n_fail++; $display("FAIL addi_done: got %b want 100", {done, busy, imem_we}); end
    n_cmp++; if (count !== 13'd1) begin n_fail++; $display("FAIL addi_count: got %0d want 1", count); end
    @(negedge clock);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL addi_done_pulse: got %b want 0", done); end
    n_cmp++; if (imem_data !== 32'h28400005) begin n_fail++; $display("FAIL addi_data_hold: got %h want 28400005", imem_data); end
  endtask

  task automatic test_back_to_back;
    do_start(12'h010);
    // add r3,r1,r2: 00000 00011 00001 00010 00000 00000 00
    set_desc(5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
    @(negedge clock);
    n_cmp++; if ({imem_we, imem_addr} !== {1'b1, 12'h010}) begin n_fail++; $display("FAIL b2b_w0: got %b@%h want 1@010", imem_we, imem_addr); end
    n_cmp++; if (imem_data !== 32'h00C22000) begin n_fail++; $display("FAIL b2b_d0: got %h want 00C22000", imem_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    set_desc(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h0000123, 1'b1);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if ({imem_we, imem_addr} !== {1'b1, 12'h011}) begin n_fail++; $display("FAIL b2b_w1: got %b@%h want 1@011", imem_we, imem_addr); end
    n_cmp++; if (imem_data !== 32'h18000123) begin n_fail++; $display("FAIL b2b_d1: got %h want 18000123", imem_data); end
    @(negedge clock);
    n_cmp++; if ({done, count} !== {1'b1, 13'd2}) begin n_fail++; $display("FAIL b2b_done: got %b/%0d want 1/2", done, count); end
    @(negedge clock);
  endtask

  task automatic test_bad_opcode;
    do_start(12'h020);
    set_desc(5'b11111, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1FFFF, 27'h7FFFFFF, 1'b1);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if ({imem_we, imem_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL bad_write: got %b/%h want 1/00000000", imem_we, imem_data); end
    n_cmp++; if (err_opcode !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err_opcode); end
    @(negedge clock);
    n_cmp++; if ({done, count} !== {1'b1, 13'd1}) begin n_fail++; $display("FAIL bad_done: got %b/%0d want 1/1", done, count); end
    @(negedge clock); @(negedge clock);
    n_cmp++; if (err_opcode !== 1'b1) begin n_fail++; $display("FAIL bad_sticky: got %b want 1", err_opcode); end
    do_start(12'h030);
    n_cmp++; if (err_opcode !== 1'b0) begin n_fail++; $display("FAIL bad_clear: got %b want 0", err_opcode); end
    set_desc(5'b00100, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if ({imem_addr, imem_data} !== {12'h030, 32'h27C00000}) begin n_fail++; $display("FAIL jr_write: got %h/%h want 030/27C00000", imem_addr, imem_data); end
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_overflow;
    do_start(12'hFFF);
    set_desc(5'b00111, 5'd2, 5'd4, 5'd0, 5'd0, 5'd0, 17'h10001, 27'd0, 1'b0);
    @(negedge clock);
    n_cmp++; if ({imem_we, imem_addr} !== {1'b1, 12'hFFF}) begin n_fail++; $display("FAIL ovf_w0: got %b@%h want 1@FFF", imem_we, imem_addr); end
    n_cmp++; if (imem_data !== 32'h38890001) begin n_fail++; $display("FAIL ovf_d0: got %h want 38890001", imem_data); end
    set_desc(5'b00101, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if ({imem_we, err_overflow, in_ready} !== 3'b010) begin n_fail++; $display("FAIL ovf_nowrite: got %b want 010", {imem_we, err_overflow, in_ready}); end
    n_cmp++; if (imem_addr !== 12'hFFF) begin n_fail++; $display("FAIL ovf_addr_hold: got %h want FFF", imem_addr); end
    @(negedge clock);
    n_cmp++; if ({done, count} !== {1'b1, 13'd1}) begin n_fail++; $display("FAIL ovf_done: got %b/%0d want 1/1", done, count); end
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_toggle_and_reset;
    do_start(12'h100);
    set_desc(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b0);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if ({imem_we, imem_addr} !== {1'b1, 12'h100}) begin n_fail++; $display("FAIL tog_w0: got %b@%h want 1@100", imem_we, imem_addr); end
    @(negedge clock);
    n_cmp++; if ({imem_we, imem_addr} !== {1'b0, 12'h100}) begin n_fail++; $display("FAIL tog_idle: got %b@%h want 0@100", imem_we, imem_addr); end
    set_desc(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd2, 27'd0, 1'b0);
    @(negedge clock); in_valid = 1'b0;
    n_cmp++; if ({imem_we, imem_addr, imem_data} !== {1'b1, 12'h101, 32'h28400002}) begin n_fail++; $display("FAIL tog_w1: got %b@%h/%h want 1@101/28400002", imem_we, imem_addr, imem_data); end
    @(negedge clock);
    n_cmp++; if ({imem_we, count} !== {1'b0, 13'd2}) begin n_fail++; $display("FAIL tog_count: got %b/%0d want 0/2", imem_we, count); end
    #1 resetn = 1'b0;
    #2;
    n_cmp++; if ({in_ready, busy, imem_we, count} !== 16'd0) begin n_fail++; $display("FAIL rst_mid_ctl: got %b%b%b/%0d want 000/0", in_ready, busy, imem_we, count); end
    n_cmp++; if ({imem_addr, imem_data} !== 44'd0) begin n_fail++; $display("FAIL rst_mid_data: got %h/%h want 0/0", imem_addr, imem_data); end
    @(negedge clock); resetn = 1'b1;
    set_desc(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd3, 27'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++; if ({imem_we, in_ready, busy, count} !== 16'd0) begin n_fail++; $display("FAIL rst_ignore_%0d: got %b%b%b/%0d want 000/0", i, imem_we, in_ready, busy, count); end
    end
    in_valid = 1'b0;
  endtask

`ifdef INSN_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    do_start(12'h040);
    set_desc(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
    @(negedge clock);
    set_desc(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h0000123, 1'b1);
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if ({done, checksum} !== {1'b1, 32'h30400126}) begin n_fail++; $display("FAIL checksum: got %b/%h want 1/30400126", done, checksum); end
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_bad_opcode();
    test_overflow();
`ifdef INSN_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_toggle_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
